// File: rtl/seq_shift_add_mult_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seq_shift_add_mult_if                                            |
// | Brief    : Operand/result handshake bundle for the shift-and-add multiplier. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seq_shift_add_mult (with nibble adder ripple_carry)              |
// | Brief    : Unsigned multi-cycle shift-and-add multiplier, one bit per cycle.|
// |            Optional macro MUL_EARLY_TERM_EN skips RUN for zero operands.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+

module ripple_carry (
    input  wire logic A0,
    input  wire logic A1,
    input  wire logic A2,
    input  wire logic A3,
    input  wire logic B0,
    input  wire logic B1,
    input  wire logic B2,
    input  wire logic B3,
    input  wire logic Cin,
    output logic      S0,
    output logic      S1,
    output logic      S2,
    output logic      S3,
    output logic      Cout3
);
    logic w_c1, w_c2, w_c3;

    assign S0    = A0 ^ B0 ^ Cin;
    assign w_c1  = (A0 & B0) | (A0 & Cin)  | (B0 & Cin);
    assign S1    = A1 ^ B1 ^ w_c1;
    assign w_c2  = (A1 & B1) | (A1 & w_c1) | (B1 & w_c1);
    assign S2    = A2 ^ B2 ^ w_c2;
    assign w_c3  = (A2 & B2) | (A2 & w_c2) | (B2 & w_c2);
    assign S3    = A3 ^ B3 ^ w_c3;
    assign Cout3 = (A3 & B3) | (A3 & w_c3) | (B3 & w_c3);
endmodule

module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seq_shift_add_mult_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(WIDTH);

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     w_hi;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [NIB:0]         w_carry;

    // Gating the addend with lo[0] makes the chain output {0,hi} when the bit is clear.
    assign w_hi       = acc_q[2*WIDTH-1:WIDTH];
    assign w_addend   = acc_q[0] ? mcand_q : '0;
    assign w_carry[0] = 1'b0;
    assign w_sum[WIDTH] = w_carry[NIB];

    genvar n;
    generate
        for (n = 0; n < NIB; n++) begin : g_nibble
            ripple_carry u_rc (
                .A0    (w_hi[4*n+0]),
                .A1    (w_hi[4*n+1]),
                .A2    (w_hi[4*n+2]),
                .A3    (w_hi[4*n+3]),
                .B0    (w_addend[4*n+0]),
                .B1    (w_addend[4*n+1]),
                .B2    (w_addend[4*n+2]),
                .B3    (w_addend[4*n+3]),
                .Cin   (w_carry[n]),
                .S0    (w_sum[4*n+0]),
                .S1    (w_sum[4*n+1]),
                .S2    (w_sum[4*n+2]),
                .S3    (w_sum[4*n+3]),
                .Cout3 (w_carry[n+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    acc_d   = {{WIDTH{1'b0}}, bus.b};
                    cnt_d   = '0;
                    state_d = S_RUN;
                    if (EARLY_TERM && (bus.a == '0 || bus.b == '0)) begin
                        product_d = '0;
                        state_d   = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Carry-out lands in the MSB as the whole accumulator shifts right.
                acc_d = {w_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = acc_d;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_seq_shift_add_mult                                            |
// | Brief    : Directed plus randomized checks of 4-bit and 8-bit multipliers.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_seq_shift_add_mult;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult_if #(.WIDTH(4)) if4 ();
    seq_shift_add_mult_if #(.WIDTH(8)) if8 ();

    seq_shift_add_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    seq_shift_add_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input int av, input int bv);
        if (w == 4) begin
            if4.start = s; if4.a = 4'(av); if4.b = 4'(bv);
        end else begin
            if8.start = s; if8.a = 8'(av); if8.b = 8'(bv);
        end
    endtask

    function automatic int get_busy(input int w);
        return (w == 4) ? int'(if4.busy) : int'(if8.busy);
    endfunction

    function automatic int get_done(input int w);
        return (w == 4) ? int'(if4.done) : int'(if8.done);
    endfunction

    function automatic int get_prod(input int w);
        return (w == 4) ? int'(if4.product) : int'(if8.product);
    endfunction

    function automatic int exp_edges(input int w, input int av, input int bv);
        return (EARLY_TERM && (av == 0 || bv == 0)) ? 1 : w + 1;
    endfunction

    // Single start pulse, then wait for done and check result, latency and pulse width.
    task automatic run_op(input string tag, input int w, input int av, input int bv);
        int edges;
        int bad;
        drive(w, 1'b1, av, bv);
        tick();
        drive(w, 1'b0, (av + 5) % (1 << w), (bv + 3) % (1 << w));
        edges = 1;
        bad   = 0;
        while (get_done(w) == 0 && edges < 40) begin
            if (get_busy(w) != 1) bad++;
            tick();
            edges++;
        end
        if (get_busy(w) != 0) bad++;
        check({tag, ".product"}, get_prod(w), av * bv);
        check({tag, ".latency"}, edges, exp_edges(w, av, bv));
        check({tag, ".busy_vs_done"}, bad, 0);
        tick();
        check({tag, ".done_one_cycle"}, get_done(w), 0);
    endtask

    initial begin
        int e;
        int seen;
        int ra, rb;

        rst = 1'b1;
        drive(4, 1'b0, 0, 0);
        drive(8, 1'b0, 0, 0);
        tick();
        tick();
        check("reset.busy4", int'(if4.busy), 0);
        check("reset.done4", int'(if4.done), 0);
        check("reset.product4", int'(if4.product), 0);
        check("reset.product8", int'(if8.product), 0);
        rst = 1'b0;
        tick();

        run_op("T1_3x5", 4, 3, 5);
        run_op("T2_15x15", 4, 15, 15);
        run_op("T3_0x9", 4, 0, 9);
        run_op("b_zero", 4, 11, 0);
        for (int i = 0; i < 8; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            run_op($sformatf("rand4_%0d", i), 4, ra, rb);
        end

        // Back-to-back starts with start held high throughout.
        drive(4, 1'b1, 7, 7);
        tick();
        drive(4, 1'b1, 3, 3);
        e = 1;
        while (if4.done == 1'b0 && e < 40) begin tick(); e++; end
        check("T4.first_product", int'(if4.product), 49);
        check("T4.first_latency", e, 5);
        drive(4, 1'b1, 10, 10);
        tick();
        drive(4, 1'b1, 1, 2);
        e = 1;
        while (if4.done == 1'b0 && e < 40) begin tick(); e++; end
        check("T4.second_product", int'(if4.product), 100);
        check("T4.pulse_spacing", e, 5);
        drive(4, 1'b0, 0, 0);
        tick();
        tick();

        // Abort mid-RUN with reset.
        drive(4, 1'b1, 9, 6);
        tick();
        drive(4, 1'b0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("T5.busy", int'(if4.busy), 0);
        check("T5.done", int'(if4.done), 0);
        check("T5.product", int'(if4.product), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.done) seen++;
        end
        check("T5.no_done_pulse", seen, 0);

        run_op("T6_200x200", 8, 200, 200);
        run_op("w8_ones", 8, 255, 255);
        run_op("w8_zero", 8, 0, 77);
        for (int i = 0; i < 5; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run_op($sformatf("rand8_%0d", i), 8, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
